// File: rtl/ff_bit.sv
`default_nettype none
// ============================================================================
// Module      : ff_bit
// Description : Enable/clear flag register for the basic-computer datapath
//               (carry, interrupt-enable, start/stop flags). Loads ff_indata
//               when enabled, clears synchronously when enabled with ff_clr,
//               and holds otherwise. Asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_bit #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ff_indata,
    input  logic             ff_clr,
    input  logic             ff_en,
    output logic [WIDTH-1:0] ff_outdata
);

    // Value loaded by a synchronous clear; independent of RESET_VALUE so that
    // a clear always yields all-zero even in non-default builds.
    localparam logic [WIDTH-1:0] C_CLEAR_VALUE = '0;

    logic [WIDTH-1:0] w_outdata_d;
    logic [WIDTH-1:0] r_outdata_q;

    // Next-state selection: hold unless enabled; clear takes priority over load.
    always_comb begin
        w_outdata_d = r_outdata_q;
        if (ff_en) begin
            if (ff_clr) begin
                w_outdata_d = C_CLEAR_VALUE;
            end else begin
                w_outdata_d = ff_indata;
            end
        end
    end

    // State register; reset acts immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outdata_q <= RESET_VALUE;
        end else begin
            r_outdata_q <= w_outdata_d;
        end
    end

    // Output is driven straight from the register: no input-to-output path.
    assign ff_outdata = r_outdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_bit
// Description : Self-checking bench for ff_bit (default 1-bit build). Inputs
//               change on the falling edge; outputs are sampled 1 ns after
//               the rising edge, or between edges for the asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_bit;

    logic clk;
    logic reset;
    logic ff_indata;
    logic ff_clr;
    logic ff_en;
    logic ff_outdata;

    int n_checks;
    int n_fails;

    ff_bit #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ff_indata  (ff_indata),
        .ff_clr     (ff_clr),
        .ff_en      (ff_en),
        .ff_outdata (ff_outdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one vector on the falling edge, then sample just after the rising edge.
    task automatic step(input logic en, input logic clr, input logic d);
        @(negedge clk);
        ff_en     = en;
        ff_clr    = clr;
        ff_indata = d;
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: {en, clr, indata, expected out after the edge}
    typedef struct packed {
        logic en;
        logic clr;
        logic d;
        logic exp;
    } vec_t;

    vec_t vecs [0:9];

    logic exp_q;
    logic r_en, r_clr, r_d, r_rst;

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b0;
        ff_en     = 1'b0;
        ff_clr    = 1'b0;
        ff_indata = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0}; // load 0
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1}; // load 1
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0}; // clear beats load
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1}; // reload 1
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1}; // hold, clr ignored
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1}; // hold
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1}; // hold
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1}; // hold, indata ignored
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0}; // load 0
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b1}; // load 1

        // Reset asserted between edges must take effect without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_val("reset_async_initial", ff_outdata, 1'b0);

        // Reset held: enabled load of 1 must not get through.
        step(1'b1, 1'b0, 1'b1);
        check_val("reset_held_load", ff_outdata, 1'b0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].d);
            check_val($sformatf("vec%0d", i), ff_outdata, vecs[i].exp);
        end

        // Output is 1 here; assert reset mid-cycle and look before the next edge.
        @(negedge clk);
        ff_en     = 1'b1;
        ff_clr    = 1'b0;
        ff_indata = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("reset_async_midcycle", ff_outdata, 1'b0);
        @(posedge clk);
        #1;
        check_val("reset_overrides_load", ff_outdata, 1'b0);

        // First edge after deassertion applies normal rules.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_reset_load", ff_outdata, 1'b1);

        // Randomised run against a behavioural reference.
        exp_q = 1'b1;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 19) == 0);
            r_en  = $urandom_range(0, 1) == 1;
            r_clr = ($urandom_range(0, 3) == 0);
            r_d   = $urandom_range(0, 1) == 1;
            reset     = r_rst;
            ff_en     = r_en;
            ff_clr    = r_clr;
            ff_indata = r_d;
            if (r_rst)
                exp_q = 1'b0;
            else if (r_en)
                exp_q = r_clr ? 1'b0 : r_d;
            @(posedge clk);
            #1;
            check_val("random", ff_outdata, exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
